// File: rtl/tpu_pkg.sv
// tpu_pkg: shared sequencer state encoding, feed length, element indices and width defaults
package tpu_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int C_W_DEF = 8;
  localparam int FEED_STEPS = 4;
  localparam int IDX_00 = 0;
  localparam int IDX_01 = 1;
  localparam int IDX_10 = 2;
  localparam int IDX_11 = 3;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLEAR, S_FEED, S_CAPTURE, S_DONE} seq_state_t;
endpackage

// File: rtl/tpu_skew_feeder.sv
// tpu_skew_feeder: maps feed step and A/B registers to skewed PE edge operands
module tpu_skew_feeder
  import tpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                    en,
  input  logic [1:0]              step,
  input  logic [3:0][DATA_W-1:0]  a,
  input  logic [3:0][DATA_W-1:0]  b,
  output logic [2*DATA_W-1:0]     pe_a_in,
  output logic [2*DATA_W-1:0]     pe_b_in
);
  localparam logic [DATA_W-1:0] Z = '0;
  assign pe_a_in = !en ? '0 :
                   step == 2'd0 ? {Z, a[IDX_00]} :
                   step == 2'd1 ? {a[IDX_10], a[IDX_01]} :
                   step == 2'd2 ? {a[IDX_11], Z} : '0;
  assign pe_b_in = !en ? '0 :
                   step == 2'd0 ? {Z, b[IDX_00]} :
                   step == 2'd1 ? {b[IDX_01], b[IDX_10]} :
                   step == 2'd2 ? {b[IDX_11], Z} : '0;
endmodule

// File: rtl/tpu_sequencer.sv
// tpu_sequencer: loads a 2x2 A/B job, drives the PE array with systolic skew, captures and serves C
module tpu_sequencer
  import tpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int C_W = C_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_en,
  input  logic                load_sel_ab,
  input  logic [1:0]          load_index,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                output_en,
  input  logic [1:0]          output_sel,
  output logic [DATA_W-1:0]   out_data,
  output logic                done,
  output logic                busy,
  output logic                pe_clear,
  output logic                pe_en,
  output logic [2*DATA_W-1:0] pe_a_in,
  output logic [2*DATA_W-1:0] pe_b_in,
  input  logic [4*C_W-1:0]    pe_c
);
  seq_state_t state_q, state_d;
  logic [1:0] step_q, step_d;
  logic [3:0][DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [3:0][C_W-1:0] c_q, c_d;
  logic [7:0] valid_q, valid_d;
  logic wr;
  assign wr = load_en && (state_q inside {S_IDLE, S_LOAD, S_DONE});
  always_comb begin
    state_d = state_q;
    step_d = step_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    valid_d = valid_q;
    if (wr) begin
      valid_d = (state_q == S_DONE ? 8'h00 : valid_q) | (8'h01 << {load_sel_ab, load_index});
      if (load_sel_ab) b_d[load_index] = in_data;
      else a_d[load_index] = in_data;
      state_d = &valid_d ? S_CLEAR : S_LOAD;
    end
    if (state_q == S_CLEAR) begin
      state_d = S_FEED;
      step_d = '0;
    end
    if (state_q == S_FEED) begin
      state_d = step_q == 2'(FEED_STEPS - 1) ? S_CAPTURE : S_FEED;
      step_d = step_q == 2'(FEED_STEPS - 1) ? step_q : step_q + 2'd1;
    end
    if (state_q == S_CAPTURE) begin
      c_d = pe_c;
      state_d = S_DONE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q <= '0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      valid_q <= valid_d;
    end
  end
  assign done = state_q == S_DONE;
  assign busy = state_q inside {S_CLEAR, S_FEED, S_CAPTURE};
  assign pe_clear = state_q == S_CLEAR;
  assign pe_en = state_q == S_FEED;
  assign out_data = output_en ? DATA_W'(c_q[output_sel]) : '0;
  tpu_skew_feeder #(.DATA_W(DATA_W)) u_feeder (
    .en(state_q == S_FEED),
    .step(step_q),
    .a(a_q),
    .b(b_q),
    .pe_a_in(pe_a_in),
    .pe_b_in(pe_b_in)
  );
endmodule
